// File: rtl/pe_pkg.sv
// Shared types, saturation helper and elaboration checks for the pe_wbuf
// processing element and its weight FIFO.
`ifndef PE_PKG_SV
`define PE_PKG_SV

`define PE_CHECK_PSUM_WIDTH(PW, DW, MAXW) \
  if (((PW) < 2*(DW)) || ((PW) >= (MAXW))) begin : g_chk_psum_width \
    $error("pe: PSUM_WIDTH must be >= 2*DATA_WIDTH and < PSUM_MAX"); \
  end

`define PE_CHECK_WBUF_DEPTH(D) \
  if ((D) < 2) begin : g_chk_wbuf_depth \
    $error("pe: WBUF_DEPTH must be >= 2"); \
  end

package pe_pkg;

  // Widest partial sum the generic saturation helper can handle.
  localparam int unsigned PSUM_MAX = 128;

  typedef struct packed {
    logic w_act_valid;
    logic err_ovf;
    logic err_udf;
  } pe_status_t;

  // Saturates a (pw+1)-bit sum, pre-extended to PSUM_MAX+1 bits, into pw bits.
  // Signed: overflow when the two top bits of the (pw+1)-bit sum disagree.
  // Unsigned: overflow when the carry bit (bit pw) is set.
  function automatic logic [PSUM_MAX-1:0] psum_sat(input logic [PSUM_MAX:0] sum,
                                                   input int unsigned     pw,
                                                   input logic            sgn);
    logic [PSUM_MAX:0]   one;
    logic [PSUM_MAX:0]   top;
    logic [PSUM_MAX:0]   nxt;
    logic [PSUM_MAX:0]   maxp;
    logic [PSUM_MAX:0]   allones;
    logic [PSUM_MAX-1:0] res;
    one     = {{PSUM_MAX{1'b0}}, 1'b1};
    top     = sum >> pw;
    nxt     = sum >> (pw - 1);
    maxp    = (one << (pw - 1)) - one;
    allones = (one << pw) - one;
    res     = sum[PSUM_MAX-1:0];
    if (sgn) begin
      if (top[0] != nxt[0]) begin
        res = top[0] ? ~maxp[PSUM_MAX-1:0] : maxp[PSUM_MAX-1:0];
      end
    end else if (top[0]) begin
      res = allones[PSUM_MAX-1:0];
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/pe_wbuf_if.sv
// Bundle of the PE's activation, partial-sum, weight-chain and status signals.
interface pe_wbuf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 40,
  parameter int WBUF_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
);
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  logic                  en_in;
  logic                  last_in;
  logic                  signed_in;
  logic [DATA_WIDTH-1:0] in;
  logic [PSUM_WIDTH-1:0] psum_in;
  logic                  w_wen_in;
  logic [TAG_WIDTH-1:0]  w_tag_in;
  logic [DATA_WIDTH-1:0] w_in;
  logic                  err_clr;

  logic                  en_out;
  logic                  last_out;
  logic                  signed_out;
  logic [DATA_WIDTH-1:0] pass_out;
  logic [PSUM_WIDTH-1:0] psum_out;
  logic                  w_wen_out;
  logic [TAG_WIDTH-1:0]  w_tag_out;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  w_act_valid;
  logic [CNT_W-1:0]      wbuf_count;
  logic                  err_ovf;
  logic                  err_udf;

  // PE side
  modport slave (
    input  en_in, last_in, signed_in, in, psum_in, w_wen_in, w_tag_in, w_in, err_clr,
    output en_out, last_out, signed_out, pass_out, psum_out, w_wen_out, w_tag_out,
           w_out, w_act_valid, wbuf_count, err_ovf, err_udf
  );

  // Neighbour / driver side
  modport master (
    output en_in, last_in, signed_in, in, psum_in, w_wen_in, w_tag_in, w_in, err_clr,
    input  en_out, last_out, signed_out, pass_out, psum_out, w_wen_out, w_tag_out,
           w_out, w_act_valid, wbuf_count, err_ovf, err_udf
  );
endinterface

// File: rtl/pe_wfifo.sv
// Synchronous weight FIFO; push and pop may coincide at any occupancy
// (a pop on an empty FIFO is ignored, a push on a full FIFO needs a pop).
module pe_wfifo #(
  parameter int DATA_WIDTH = 16,
  parameter int WBUF_DEPTH = 4,
  parameter int CNT_W      = $clog2(WBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] head_o
);
  import pe_pkg::*;

  localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [WBUF_DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(WBUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count next state with manual wrap for non-power-of-two depths
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/pe_wbuf.sv
// Systolic MAC processing element with tag-addressed weight FIFO:
// psum_out = sat(psum_in + in * w_act), signed or unsigned per beat.
module pe_wbuf #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 40,
  parameter int WBUF_DEPTH = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int ROW_ID     = 0
) (
  input logic     clk,
  input logic     rst,
  pe_wbuf_if.slave bus
);
  import pe_pkg::*;

  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int DW2   = 2 * DATA_WIDTH;

  `PE_CHECK_PSUM_WIDTH(PSUM_WIDTH, DATA_WIDTH, PSUM_MAX)
  `PE_CHECK_WBUF_DEPTH(WBUF_DEPTH)

  // Module-width wrapper around the generic package saturator.
  function automatic logic [PSUM_WIDTH-1:0] sat_psum(input logic [PSUM_WIDTH:0] sum,
                                                     input logic              sgn);
    logic [PSUM_MAX:0] sum_ext;
    sum_ext = {{(PSUM_MAX - PSUM_WIDTH){sgn & sum[PSUM_WIDTH]}}, sum};
    return PSUM_WIDTH'(psum_sat(sum_ext, PSUM_WIDTH, sgn));
  endfunction

  logic                  fifo_push, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  cap, load, retire, ovf_evt, udf_evt;

  logic [DATA_WIDTH-1:0] w_act_q, w_act_d;
  pe_status_t            status_q, status_d;

  logic                  en_q, last_q, sgn_q, wen_q;
  logic [DATA_WIDTH-1:0] pass_q, wout_q;
  logic [PSUM_WIDTH-1:0] psum_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic signed [DW2-1:0]        a_x, b_x, prod;
  logic        [DATA_WIDTH-1:0] w_eff;
  logic        [PSUM_WIDTH:0]   prod_x, psum_x, sum;
  logic        [PSUM_WIDTH-1:0] mac_res;

  pe_wfifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .WBUF_DEPTH (WBUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (load),
    .din_i   (bus.w_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Capture / load / retire control and sticky error next state
  always_comb begin
    cap       = bus.w_wen_in && (bus.w_tag_in == TAG_WIDTH'(ROW_ID));
    load      = !status_q.w_act_valid && !fifo_empty;
    retire    = bus.en_in && bus.last_in && status_q.w_act_valid;
    ovf_evt   = cap && fifo_full && !load;
    udf_evt   = bus.en_in && !status_q.w_act_valid;
    fifo_push = cap && !ovf_evt;
    w_act_d   = load ? fifo_head : w_act_q;
    status_d.w_act_valid = load | (status_q.w_act_valid & ~retire);
    status_d.err_ovf     = ovf_evt | (status_q.err_ovf & ~bus.err_clr);
    status_d.err_udf     = udf_evt | (status_q.err_udf & ~bus.err_clr);
  end

  // MAC: operands extended per signed_in, sum one bit wider, then saturated
  always_comb begin
    w_eff   = status_q.w_act_valid ? w_act_q : '0;
    a_x     = {{DATA_WIDTH{bus.signed_in & bus.in[DATA_WIDTH-1]}}, bus.in};
    b_x     = {{DATA_WIDTH{bus.signed_in & w_eff[DATA_WIDTH-1]}}, w_eff};
    prod    = a_x * b_x;
    prod_x  = {{(PSUM_WIDTH + 1 - DW2){bus.signed_in & prod[DW2-1]}}, prod};
    psum_x  = {bus.signed_in & bus.psum_in[PSUM_WIDTH-1], bus.psum_in};
    sum     = psum_x + prod_x;
    mac_res = sat_psum(sum, bus.signed_in);
  end

  // Stage p0 -> outputs: registered activation, psum and weight-chain forward
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
      sgn_q  <= 1'b0;
      pass_q <= '0;
      psum_q <= '0;
      wen_q  <= 1'b0;
      tag_q  <= '0;
      wout_q <= '0;
    end else begin
      en_q   <= bus.en_in;
      last_q <= bus.en_in & bus.last_in;
      sgn_q  <= bus.signed_in;
      wen_q  <= bus.w_wen_in;
      tag_q  <= bus.w_tag_in;
      wout_q <= bus.w_wen_in ? bus.w_in : '0;
      if (bus.en_in) begin
        pass_q <= bus.in;
        psum_q <= mac_res;
      end
    end
  end

  // Active weight register and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      w_act_q  <= '0;
      status_q <= '0;
    end else begin
      w_act_q  <= w_act_d;
      status_q <= status_d;
    end
  end

  assign bus.en_out      = en_q;
  assign bus.last_out    = last_q;
  assign bus.signed_out  = sgn_q;
  assign bus.pass_out    = pass_q;
  assign bus.psum_out    = psum_q;
  assign bus.w_wen_out   = wen_q;
  assign bus.w_tag_out   = tag_q;
  assign bus.w_out       = wout_q;
  assign bus.w_act_valid = status_q.w_act_valid;
  assign bus.wbuf_count  = fifo_count;
  assign bus.err_ovf     = status_q.err_ovf;
  assign bus.err_udf     = status_q.err_udf;

endmodule

// File: tb/tb_pe_wbuf.sv
// Scoreboard bench for pe_wbuf: a behavioural model predicts the registered
// outputs for every driven cycle; directed scenarios add hand-derived checks.
module tb_pe_wbuf;

  localparam int DW  = 16;
  localparam int PW  = 40;
  localparam int DEP = 4;
  localparam int TW  = 4;
  localparam int RID = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_wbuf_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .WBUF_DEPTH(DEP), .TAG_WIDTH(TW)) bus ();

  pe_wbuf #(
    .DATA_WIDTH (DW),
    .PSUM_WIDTH (PW),
    .WBUF_DEPTH (DEP),
    .TAG_WIDTH  (TW),
    .ROW_ID     (RID)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          en, last, sgn;
    logic [DW-1:0] pass;
    logic [PW-1:0] psum;
    logic          wen;
    logic [TW-1:0] tag;
    logic [DW-1:0] wout;
    logic          actv;
    logic [2:0]    cnt;
    logic          ovf, udf;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          m_out;
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_act;
  logic          m_actv, m_ovf, m_udf;

  int n_vec = 0;
  int n_err = 0;

  logic          i_rst, i_en, i_last, i_sgn, i_wen, i_clr;
  logic [DW-1:0] i_in, i_w;
  logic [PW-1:0] i_psum;
  logic [TW-1:0] i_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mac(input logic [PW-1:0] p, input logic [DW-1:0] a,
                                        input logic [DW-1:0] w, input logic s);
    longint pa, aa, ww, r;
    if (s) begin
      pa = longint'($signed(p));
      aa = longint'($signed(a));
      ww = longint'($signed(w));
      r  = pa + aa * ww;
      if (r > 64'sd549755813887)  r = 64'sd549755813887;
      if (r < -64'sd549755813888) r = -64'sd549755813888;
    end else begin
      pa = longint'({24'd0, p});
      aa = longint'({48'd0, a});
      ww = longint'({48'd0, w});
      r  = pa + aa * ww;
      if (r > 64'sd1099511627775) r = 64'sd1099511627775;
    end
    return r[PW-1:0];
  endfunction

  task automatic idle_in();
    i_rst = 1'b0; i_en = 1'b0; i_last = 1'b0; i_sgn = 1'b0; i_wen = 1'b0; i_clr = 1'b0;
    i_in = '0; i_w = '0; i_psum = '0; i_tag = '0;
  endtask

  task automatic wpush(input logic [TW-1:0] tag, input logic [DW-1:0] w);
    idle_in();
    i_wen = 1'b1; i_tag = tag; i_w = w;
  endtask

  task automatic beat(input logic [DW-1:0] a, input logic [PW-1:0] p, input logic s,
                      input logic l);
    idle_in();
    i_en = 1'b1; i_in = a; i_psum = p; i_sgn = s; i_last = l;
  endtask

  // Drive one cycle, predict its outputs, then compare after the edge.
  task automatic step();
    exp_t e;
    logic load, cap, ovf_e, udf_e, retire;
    logic [DW-1:0] wv;
    rst           = i_rst;
    bus.en_in     = i_en;
    bus.last_in   = i_last;
    bus.signed_in = i_sgn;
    bus.in        = i_in;
    bus.psum_in   = i_psum;
    bus.w_wen_in  = i_wen;
    bus.w_tag_in  = i_tag;
    bus.w_in      = i_w;
    bus.err_clr   = i_clr;
    e = m_out;
    if (i_rst) begin
      e = '{default: '0};
      m_fifo.delete();
      m_act = '0; m_actv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      e.wen  = i_wen;
      e.tag  = i_tag;
      e.wout = i_wen ? i_w : '0;
      e.en   = i_en;
      e.sgn  = i_sgn;
      e.last = i_en & i_last;
      wv = m_actv ? m_act : '0;
      if (i_en) begin
        e.pass = i_in;
        e.psum = mac(i_psum, i_in, wv, i_sgn);
      end
      load   = !m_actv && (m_fifo.size() > 0);
      cap    = i_wen && (i_tag == TW'(RID));
      udf_e  = i_en && !m_actv;
      retire = i_en && i_last && m_actv;
      ovf_e  = 1'b0;
      if (load) m_act = m_fifo.pop_front();
      if (cap) begin
        if (m_fifo.size() < DEP) m_fifo.push_back(i_w);
        else ovf_e = 1'b1;
      end
      m_actv = load ? 1'b1 : (retire ? 1'b0 : m_actv);
      m_ovf  = ovf_e | (m_ovf & ~i_clr);
      m_udf  = udf_e | (m_udf & ~i_clr);
      e.actv = m_actv;
      e.cnt  = 3'(m_fifo.size());
      e.ovf  = m_ovf;
      e.udf  = m_udf;
    end
    m_out = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("en_out",      64'(bus.en_out),      64'(e.en));
    chk("last_out",    64'(bus.last_out),    64'(e.last));
    chk("signed_out",  64'(bus.signed_out),  64'(e.sgn));
    chk("pass_out",    64'(bus.pass_out),    64'(e.pass));
    chk("psum_out",    64'(bus.psum_out),    64'(e.psum));
    chk("w_wen_out",   64'(bus.w_wen_out),   64'(e.wen));
    chk("w_tag_out",   64'(bus.w_tag_out),   64'(e.tag));
    chk("w_out",       64'(bus.w_out),       64'(e.wout));
    chk("w_act_valid", 64'(bus.w_act_valid), 64'(e.actv));
    chk("wbuf_count",  64'(bus.wbuf_count),  64'(e.cnt));
    chk("err_ovf",     64'(bus.err_ovf),     64'(e.ovf));
    chk("err_udf",     64'(bus.err_udf),     64'(e.udf));
  endtask

  task automatic do_reset();
    idle_in();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    m_out = '{default: '0};
    m_act = '0; m_actv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    idle_in();
    rst = 1'b1;
    bus.en_in = 1'b0; bus.last_in = 1'b0; bus.signed_in = 1'b0; bus.in = '0;
    bus.psum_in = '0; bus.w_wen_in = 1'b0; bus.w_tag_in = '0; bus.w_in = '0;
    bus.err_clr = 1'b0;

    // Reset, then tag-filtered capture and forwarding
    do_reset();
    do_reset();
    chk("rst_psum", 64'(bus.psum_out), 64'd0);
    chk("rst_cnt",  64'(bus.wbuf_count), 64'd0);
    wpush(4'd2, 16'd5); step();
    chk("cap_cnt1", 64'(bus.wbuf_count), 64'd1);
    chk("cap_fwd5", 64'(bus.w_out), 64'd5);
    wpush(4'd3, 16'd9); step();
    chk("cap_load", 64'(bus.w_act_valid), 64'd1);
    chk("cap_cnt0", 64'(bus.wbuf_count), 64'd0);
    chk("cap_fwd9", 64'(bus.w_out), 64'd9);
    wpush(4'd2, 16'd7); step();
    chk("cap_cnt1b", 64'(bus.wbuf_count), 64'd1);
    chk("cap_fwd7",  64'(bus.w_out), 64'd7);
    idle_in(); step();
    chk("fwd_idle", 64'(bus.w_out), 64'd0);

    // Signed / unsigned MAC with w_act = -3
    do_reset();
    wpush(4'd2, 16'hFFFD); step();
    idle_in(); step();
    beat(16'd4, 40'd10, 1'b1, 1'b0); step();
    chk("smac", 64'(bus.psum_out), 64'h00FF_FFFF_FFFE);
    beat(16'd4, 40'd10, 1'b0, 1'b0); step();
    chk("umac", 64'(bus.psum_out), 64'h3_FFFE);

    // Saturation: retire -3 while pushing 0x7FFF, then 0x8000
    beat(16'd0, 40'd0, 1'b1, 1'b1);
    i_wen = 1'b1; i_tag = 4'd2; i_w = 16'h7FFF;
    step();
    chk("ret_actv", 64'(bus.w_act_valid), 64'd0);
    wpush(4'd2, 16'h8000); step();
    beat(16'h7FFF, 40'h7F_FFFF_FFFE, 1'b1, 1'b1); step();
    chk("sat_pos", 64'(bus.psum_out), 64'h7F_FFFF_FFFF);
    idle_in(); step();
    beat(16'h7FFF, 40'h80_0000_0001, 1'b1, 1'b1); step();
    chk("sat_neg", 64'(bus.psum_out), 64'h80_0000_0000);
    wpush(4'd2, 16'hFFFF); step();
    idle_in(); step();
    beat(16'hFFFF, 40'hFF_FFFF_0000, 1'b0, 1'b1); step();
    chk("sat_uns", 64'(bus.psum_out), 64'hFF_FFFF_FFFF);

    // Tile switch: weights 5 then 7, one gap cycle between tiles
    do_reset();
    wpush(4'd2, 16'd5); step();
    wpush(4'd2, 16'd7); step();
    beat(16'd1, 40'd0, 1'b1, 1'b0); step();
    chk("tile_b1", 64'(bus.psum_out), 64'd5);
    beat(16'd2, 40'd0, 1'b1, 1'b0); step();
    beat(16'd3, 40'd0, 1'b1, 1'b1); step();
    chk("tile_b3", 64'(bus.psum_out), 64'd15);
    chk("tile_gap", 64'(bus.w_act_valid), 64'd0);
    idle_in(); step();
    chk("tile_reload", 64'(bus.w_act_valid), 64'd1);
    beat(16'd2, 40'd0, 1'b1, 1'b0); step();
    chk("tile_w7", 64'(bus.psum_out), 64'd14);

    // Overflow, underflow and clearing
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      wpush(4'd2, 16'(k)); step();
    end
    chk("ovf_cnt",  64'(bus.wbuf_count), 64'd4);
    chk("ovf_flag", 64'(bus.err_ovf), 64'd1);
    for (int k = 0; k < 5; k++) begin
      beat(16'd1, 40'd0, 1'b0, 1'b1); step();
      idle_in(); step();
    end
    beat(16'd3, 40'd123, 1'b1, 1'b0); step();
    chk("udf_flag", 64'(bus.err_udf), 64'd1);
    chk("udf_psum", 64'(bus.psum_out), 64'd123);
    idle_in(); i_clr = 1'b1; step();
    chk("clr_ovf", 64'(bus.err_ovf), 64'd0);
    chk("clr_udf", 64'(bus.err_udf), 64'd0);
    beat(16'd1, 40'd1, 1'b0, 1'b0); i_clr = 1'b1; step();
    chk("clr_race", 64'(bus.err_udf), 64'd1);
    idle_in(); i_clr = 1'b1; step();

    // Reset mid-tile with three buffered weights
    for (int k = 11; k <= 14; k++) begin
      wpush(4'd2, 16'(k)); step();
    end
    beat(16'd1, 40'd5, 1'b1, 1'b0); step();
    chk("mt_psum", 64'(bus.psum_out), 64'd16);
    beat(16'd1, 40'd5, 1'b1, 1'b0); i_rst = 1'b1; step();
    chk("mt_rst_psum", 64'(bus.psum_out), 64'd0);
    chk("mt_rst_cnt",  64'(bus.wbuf_count), 64'd0);
    chk("mt_rst_en",   64'(bus.en_out), 64'd0);
    beat(16'd2, 40'd7, 1'b1, 1'b0); step();
    chk("mt_nostale", 64'(bus.psum_out), 64'd7);
    chk("mt_udf",     64'(bus.err_udf), 64'd1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle_in();
      i_rst  = ($urandom_range(99, 0) == 0);
      i_en   = $urandom_range(1, 0) == 1;
      i_last = $urandom_range(3, 0) == 0;
      i_sgn  = $urandom_range(1, 0) == 1;
      i_in   = DW'($urandom());
      i_psum = PW'({$urandom(), $urandom()});
      i_wen  = $urandom_range(2, 0) != 0;
      i_tag  = ($urandom_range(2, 0) == 0) ? 4'd3 : 4'd2;
      i_w    = DW'($urandom());
      i_clr  = $urandom_range(15, 0) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
